// File: rtl/updown_counter_74ls191_pkg.sv
// Shared constants and types for the 74LS191-style up/down counter.
// Both the counter top and its next-state logic import this package.
package updown_counter_74ls191_pkg;

  localparam int MOD_BIN = 16;
  localparam int MOD_BCD = 10;
  localparam int CNT_W   = 4;

  typedef logic [CNT_W-1:0] count_t;

  // D_U pin encoding
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2
  } op_e;

  function automatic bit modulus_legal(input int m);
    return (m == MOD_BIN) || (m == MOD_BCD);
  endfunction

  // Highest legal count for a given modulus; the up-count terminal value.
  function automatic count_t top_value(input int m);
    return count_t'(m - 1);
  endfunction

endpackage

// File: rtl/updown_counter_74ls191_next_state.sv
// Combinational next-count and terminal-count logic for one counter digit.
// Out-of-range states wrap to 0 going up and decrement normally going down.
module updown_next_state
  import updown_counter_74ls191_pkg::*;
#(
  parameter int MODULUS = MOD_BIN
) (
  input  logic [CNT_W-1:0] q,
  input  logic             d_u,
  output logic [CNT_W-1:0] q_next,
  output logic             term
);

  localparam count_t TOP = top_value(MODULUS);

  always_comb begin
    q_next = q;
    term   = 1'b0;
    if (d_u == DIR_UP) begin
      term = (q == TOP);
      // >= rather than == so illegal BCD states recover in a single clock
      if (q >= TOP) begin
        q_next = '0;
      end else begin
        q_next = q + count_t'(1);
      end
    end else begin
      term = (q == '0);
      if (q == '0) begin
        q_next = TOP;
      end else begin
        q_next = q - count_t'(1);
      end
    end
  end

endmodule

// File: rtl/updown_counter_74ls191.sv
// 4-bit presettable up/down counter (74LS191 behaviour), binary or BCD modulus.
// RCO_n is gated by CP low so its rising edge can clock a cascaded stage.
module updown_counter_74ls191
  import updown_counter_74ls191_pkg::*;
#(
  parameter int MODULUS = MOD_BIN
) (
  input  logic CP,
  input  logic CR_n,
  input  logic LD_n,
  input  logic CTEN_n,
  input  logic D_U,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic MAX_MIN,
  output logic RCO_n
);

  generate
    if (!modulus_legal(MODULUS)) begin : g_bad_modulus
      $error("updown_counter_74ls191: MODULUS must be 10 or 16, got %0d", MODULUS);
    end
  endgenerate

  count_t count_reg;
  count_t count_next;
  count_t load_value;
  count_t step_value;
  logic   term;
  op_e    op;

  assign load_value = {D3, D2, D1, D0};

  updown_next_state #(
    .MODULUS (MODULUS)
  ) u_next_state (
    .q      (count_reg),
    .d_u    (D_U),
    .q_next (step_value),
    .term   (term)
  );

  // Load outranks count enable; direction only matters when counting.
  always_comb begin
    op = OP_HOLD;
    if (!LD_n) begin
      op = OP_LOAD;
    end else if (!CTEN_n) begin
      op = OP_COUNT;
    end
  end

  always_comb begin
    count_next = count_reg;
    case (op)
      OP_LOAD:  count_next = load_value;
      OP_COUNT: count_next = step_value;
      default:  count_next = count_reg;
    endcase
  end

  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign Q0 = count_reg[0];
  assign Q1 = count_reg[1];
  assign Q2 = count_reg[2];
  assign Q3 = count_reg[3];

  assign MAX_MIN = term;
  assign RCO_n   = ~(term & ~CTEN_n & ~CP);

endmodule
